koa_divider: RTL and testbench

//  Sequential unsigned divider; the inverse of koa_multiplier. It takes a 2*DATA_WIDTH dividend
//  (e.g. a product mult_d) and a DATA_WIDTH divisor. It returns a DATA_WIDTH quotient and remainder.

---
 rtl/koa_pkg.sv | 15 +
 rtl/koa_div_step.sv | 21 ++
 rtl/koa_divider.sv | 117 +++++++++++
 tb/tb_koa_divider.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/koa_pkg.sv
// Shared arithmetic-datapath types: operand widths and the divider state encoding.
package koa_pkg;

    localparam int DATA_WIDTH = 128;

    typedef logic [DATA_WIDTH-1:0]   operand_t;
    typedef logic [2*DATA_WIDTH-1:0] product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/koa_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the divisor if it fits.
module koa_div_step #(
    parameter int DW = 128
) (
    input  logic [DW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] dvsr,
    output logic [DW-1:0] rem_out,
    output logic          q_bit
);

    logic [DW:0] t;

    // t needs DW+1 bits; once reduced below dvsr the result fits back into DW bits.
    always_comb begin
        t       = {rem_in, bit_in};
        q_bit   = (t >= {1'b0, dvsr});
        rem_out = q_bit ? DW'(t - {1'b0, dvsr}) : t[DW-1:0];
    end

endmodule

// File: rtl/koa_divider.sv
// Sequential unsigned divider, 2*DW / DW, one quotient bit per clock, valid/ready both sides.
//   state | meaning
//   IDLE  | waiting for a request, div_ready=1
//   CALC  | one restoring step per cycle, DW steps total
//   DONE  | result presented, held until quo_ready
module koa_divider
    import koa_pkg::*;
#(
    parameter int DATA_WIDTH = koa_pkg::DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      div_valid,
    output logic                      div_ready,
    input  logic [2*DATA_WIDTH-1:0]   div_n,
    input  logic [DATA_WIDTH-1:0]     div_d,
    output logic                      quo_valid,
    input  logic                      quo_ready,
    output logic [DATA_WIDTH-1:0]     quo_q,
    output logic [DATA_WIDTH-1:0]     quo_r,
    output logic                      quo_ovf
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW);

    div_state_e     state_q, state_d;
    logic [DW-1:0]  rem_q, rem_d;
    logic [DW-1:0]  shift_q, shift_d;
    logic [DW-1:0]  dvsr_q, dvsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;

    logic [DW-1:0]  n_hi;
    logic [DW-1:0]  step_rem;
    logic           step_bit;

    assign n_hi = div_n[2*DW-1:DW];

    koa_div_step #(.DW(DW)) u_step (
        .rem_in  (rem_q),
        .bit_in  (shift_q[DW-1]),
        .dvsr    (dvsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            shift_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (div_valid) begin
                    dvsr_d = div_d;
                    if (div_d == '0) begin
                        shift_d = '1;
                        rem_d   = div_n[DW-1:0];
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else if (n_hi >= div_d) begin
                        // quotient would need more than DW bits
                        shift_d = '1;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = n_hi;
                        shift_d = div_n[DW-1:0];
                        cnt_d   = CW'(DW - 1);
                        ovf_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // quotient bits fill the shift register from the bottom as dividend bits leave the top
                shift_d = {shift_q[DW-2:0], step_bit};
                rem_d   = step_rem;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (quo_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_ready = (state_q == IDLE);
    assign quo_valid = (state_q == DONE);
    assign quo_q     = shift_q;
    assign quo_r     = rem_q;
    assign quo_ovf   = ovf_q;

endmodule

// File: tb/tb_koa_divider.sv
// Self-checking bench for koa_divider: directed vector table, corner sequences, random vs. arithmetic model.
module tb_koa_divider;

    localparam int DW = 128;
    localparam int TMO = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic              div_valid;
    logic              div_ready;
    logic [2*DW-1:0]   div_n;
    logic [DW-1:0]     div_d;
    logic              quo_valid;
    logic              quo_ready;
    logic [DW-1:0]     quo_q;
    logic [DW-1:0]     quo_r;
    logic              quo_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string           name;
        logic [2*DW-1:0] n;
        logic [DW-1:0]   d;
        logic [DW-1:0]   q;
        logic [DW-1:0]   r;
        logic            ovf;
        int              lat;
    } vec_t;

    vec_t vecs[$];

    koa_divider #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_n     (div_n),
        .div_d     (div_d),
        .quo_valid (quo_valid),
        .quo_ready (quo_ready),
        .quo_q     (quo_q),
        .quo_r     (quo_r),
        .quo_ovf   (quo_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Issue one request with quo_ready=1, return the result and latency in cycles after accept.
    task automatic run_op(input logic [2*DW-1:0] n, input logic [DW-1:0] d,
                          output logic [DW-1:0] q, output logic [DW-1:0] r,
                          output logic ovf, output int lat);
        int w;
        @(negedge clk);
        div_n = n; div_d = d; div_valid = 1'b1; quo_ready = 1'b1;
        w = 0;
        while (!div_ready && w < TMO) begin @(negedge clk); w++; end
        if (w >= TMO) chk("accept_timeout", 0, 1);
        @(negedge clk);
        div_valid = 1'b0;
        div_n = {rnd128(), rnd128()};
        div_d = rnd128();
        lat = 1;
        while (!quo_valid && lat < TMO) begin @(negedge clk); lat++; end
        q = quo_q; r = quo_r; ovf = quo_ovf;
    endtask

    initial begin
        logic [DW-1:0]   a, b, q, r, q0, r0;
        logic [2*DW-1:0] n;
        logic [DW-1:0]   d;
        logic            ovf, ovf0, stable;
        int              lat;

        a = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;
        b = 128'h0123456789ABCDEFDEADBEEFCAFEBABE;
        vecs.push_back('{"inverse", {128'b0, a} * {128'b0, b}, b, a, 0, 0, DW+1});
        vecs.push_back('{"n1000_d7", 256'd1000, 128'd7, 128'd142, 128'd6, 0, DW+1});
        vecs.push_back('{"n0_d5", 256'd0, 128'd5, 128'd0, 128'd0, 0, DW+1});
        vecs.push_back('{"div_by_zero", 256'h1234, 128'd0, '1, 128'h1234, 1, 1});
        vecs.push_back('{"ovf_exit", {128'h5, 128'h0}, 128'h5, '1, 128'd0, 1, 1});
        vecs.push_back('{"n_lo_max_d1", {128'h0, {DW{1'b1}}}, 128'd1, '1, 128'd0, 0, DW+1});
        vecs.push_back('{"n_hi_dm1", {{DW{1'b1}} - 128'd1, {DW{1'b1}}}, '1, '1, {DW{1'b1}} - 128'd1, 0, DW+1});
        vecs.push_back('{"n255_d16", 256'd255, 128'd16, 128'd15, 128'd15, 0, DW+1});

        rst = 1'b1; div_valid = 1'b0; quo_ready = 1'b1; div_n = '0; div_d = '0;
        repeat (3) @(negedge clk);
        chk("rst_div_ready", div_ready, 1);
        chk("rst_quo_valid", quo_valid, 0);
        chk("rst_quo_q", quo_q, 0);
        chk("rst_quo_r", quo_r, 0);
        chk("rst_quo_ovf", quo_ovf, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].n, vecs[i].d, q, r, ovf, lat);
            chk({vecs[i].name, "_q"}, q, vecs[i].q);
            chk({vecs[i].name, "_r"}, r, vecs[i].r);
            chk({vecs[i].name, "_ovf"}, ovf, vecs[i].ovf);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
        end

        // Backpressure: hold result for 20 cycles, then release with the next request already pending.
        @(negedge clk);
        quo_ready = 1'b0;
        div_n = 256'd1000; div_d = 128'd7; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        lat = 1;
        while (!quo_valid && lat < TMO) begin @(negedge clk); lat++; end
        chk("bp_lat", lat, DW+1);
        q0 = quo_q; r0 = quo_r; ovf0 = quo_ovf;
        chk("bp_q", q0, 128'd142);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (quo_q !== q0 || quo_r !== r0 || quo_ovf !== ovf0 || !quo_valid || div_ready)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        quo_ready = 1'b1;
        div_n = 256'd255; div_d = 128'd16; div_valid = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", quo_valid, 0);
        chk("bp_release_ready", div_ready, 1);
        @(negedge clk);
        div_valid = 1'b0;
        chk("bp_next_accepted", div_ready, 0);
        lat = 1;
        while (!quo_valid && lat < TMO) begin @(negedge clk); lat++; end
        chk("bp_next_q", quo_q, 128'd15);
        chk("bp_next_r", quo_r, 128'd15);

        // Reset in the middle of a calculation.
        @(negedge clk);
        div_n = {128'h1, rnd128()}; div_d = 128'h77; div_valid = 1'b1;
        @(negedge clk);
        div_valid = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_calc_busy", div_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", div_ready, 1);
        chk("rst_mid_valid", quo_valid, 0);
        stable = 1'b1;
        repeat (DW + 5) begin
            @(negedge clk);
            if (quo_valid) stable = 1'b0;
        end
        chk("rst_no_stale", stable, 1);
        run_op(256'd255, 128'd16, q, r, ovf, lat);
        chk("rst_fresh_q", q, 128'd15);
        chk("rst_fresh_r", r, 128'd15);

        // Random operands checked against native wide division.
        for (int k = 0; k < 300; k++) begin
            logic [2*DW-1:0] eq, er;
            logic            eo;
            d = rnd128() >> $urandom_range(0, DW-1);
            case ($urandom_range(0, 19))
                0:       d = '0;
                1:       n = {d + rnd128() % ({DW{1'b1}} - d + 1), rnd128()};
                default: n = {128'h0, rnd128()};
            endcase
            if (d != '0 && $urandom_range(0, 19) > 1) n = {rnd128() % d, rnd128()};
            if (d == '0) begin
                eq = {128'h0, {DW{1'b1}}}; er = {128'h0, n[DW-1:0]}; eo = 1'b1;
            end else if (n / d > {128'h0, {DW{1'b1}}}) begin
                eq = {128'h0, {DW{1'b1}}}; er = '0; eo = 1'b1;
            end else begin
                eq = n / d; er = n % d; eo = 1'b0;
            end
            run_op(n, d, q, r, ovf, lat);
            if (eo) begin
                chk("rand_ovf_q", q, eq);
                chk("rand_ovf_r", r, er);
                chk("rand_ovf_flag", ovf, 1);
            end else begin
                chk("rand_q", q, eq);
                chk("rand_r", r, er);
                chk("rand_flag", ovf, 0);
                chk("rand_invariant", ({128'h0, q} * {128'h0, d} + {128'h0, r} == n) && (r < d), 1);
                chk("rand_lat", lat, DW+1);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
